// File: rtl/cv32e40x_pkg.sv
// Shared CLIC arbiter types: trigger mode, per-source config record, output FSM states.
package cv32e40x_pkg;

  localparam logic [1:0] PRIV_LVL_M = 2'b11;

  typedef enum logic {
    CLIC_TRIG_LEVEL = 1'b0,
    CLIC_TRIG_EDGE  = 1'b1
  } clic_trig_e;

  typedef struct packed {
    logic       ie;
    logic [7:0] level;
    logic       shv;
    clic_trig_e trig;
  } clic_src_cfg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } clic_arb_state_e;

endpackage

// File: rtl/cv32e40x_clic_arb_tree.sv
// Combinational max-level selection over all sources; ties go to the higher ID.
module cv32e40x_clic_arb_tree #(
  parameter int unsigned NUM_SRC       = 16,
  parameter int unsigned CLIC_ID_WIDTH = 5
) (
  input  logic [NUM_SRC-1:0]       i_eligible,
  input  logic [NUM_SRC*8-1:0]     i_level,
  input  logic [NUM_SRC-1:0]       i_shv,
  output logic                     o_valid,
  output logic [CLIC_ID_WIDTH-1:0] o_id,
  output logic [7:0]               o_level,
  output logic                     o_shv
);

  localparam int unsigned LEAVES = 2 ** $clog2(NUM_SRC);
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic                     w_vld [NODES];
  logic [CLIC_ID_WIDTH-1:0] w_id  [NODES];
  logic [7:0]               w_lvl [NODES];
  logic                     w_shv [NODES];
  logic                     w_pick;
  int unsigned              w_n;

  // Heap layout: node n has children 2n+1 (lower IDs) and 2n+2 (higher IDs),
  // so preferring the right child on equal levels gives the higher-ID tie rule.
  always_comb begin
    w_pick = 1'b0;
    w_n    = 0;
    for (int unsigned l = 0; l < LEAVES; l++) begin
      if (l < NUM_SRC) begin
        w_vld[LEAVES-1+l] = i_eligible[l];
        w_id[LEAVES-1+l]  = CLIC_ID_WIDTH'(l);
        w_lvl[LEAVES-1+l] = i_level[l*8 +: 8];
        w_shv[LEAVES-1+l] = i_shv[l];
      end else begin
        w_vld[LEAVES-1+l] = 1'b0;
        w_id[LEAVES-1+l]  = '0;
        w_lvl[LEAVES-1+l] = '0;
        w_shv[LEAVES-1+l] = 1'b0;
      end
    end
    for (int unsigned j = 0; j < LEAVES - 1; j++) begin
      w_n    = LEAVES - 2 - j;
      w_pick = w_vld[2*w_n+2] && (!w_vld[2*w_n+1] || (w_lvl[2*w_n+2] >= w_lvl[2*w_n+1]));
      w_vld[w_n] = w_vld[2*w_n+1] || w_vld[2*w_n+2];
      w_id[w_n]  = w_pick ? w_id[2*w_n+2]  : w_id[2*w_n+1];
      w_lvl[w_n] = w_pick ? w_lvl[2*w_n+2] : w_lvl[2*w_n+1];
      w_shv[w_n] = w_pick ? w_shv[2*w_n+2] : w_shv[2*w_n+1];
    end
  end

  assign o_valid = w_vld[0];
  assign o_id    = w_id[0];
  assign o_level = w_lvl[0];
  assign o_shv   = w_shv[0];

endmodule

// File: rtl/cv32e40x_clic_int_arbiter.sv
// CLIC source arbiter: pending tracking, per-source config and clic_irq_* presentation.
// Edge-triggered sources are built only when CV32E40X_CLIC_EDGE_TRIG_EN is defined.
module cv32e40x_clic_int_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 16,
  parameter int unsigned CLIC_ID_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       irq_src_i,
  input  logic                     cfg_we_i,
  input  logic [CLIC_ID_WIDTH-1:0] cfg_id_i,
  input  logic                     cfg_ie_i,
  input  logic [7:0]               cfg_level_i,
  input  logic                     cfg_shv_i,
  input  logic                     cfg_trig_i,
  input  logic                     irq_ack_i,
  input  logic [CLIC_ID_WIDTH-1:0] irq_ack_id_i,
  output logic                     clic_irq_o,
  output logic [CLIC_ID_WIDTH-1:0] clic_irq_id_o,
  output logic [7:0]               clic_irq_level_o,
  output logic [1:0]               clic_irq_priv_o,
  output logic                     clic_irq_shv_o,
  output logic [NUM_SRC-1:0]       pending_o
);

  if (NUM_SRC < 2 || NUM_SRC > 2 ** CLIC_ID_WIDTH) begin : g_cfg_check
    $error("cv32e40x_clic_int_arbiter: NUM_SRC must lie in 2..2**CLIC_ID_WIDTH");
  end

  logic [NUM_SRC-1:0]        r_irq_q;
  logic [NUM_SRC-1:0]        r_ie;
  logic [NUM_SRC-1:0]        r_shv;
  logic [NUM_SRC-1:0][7:0]   r_level;
  clic_src_cfg_t             w_wr_cfg;
  logic [NUM_SRC-1:0]        w_wr_sel;
  logic [NUM_SRC-1:0]        w_lvl_nz;
  logic [NUM_SRC-1:0]        w_pending;
  logic [NUM_SRC-1:0]        w_eligible;
  logic                      w_ack_vld;

  clic_arb_state_e           r_state, w_state_nxt;
  logic                      w_load;
  logic [CLIC_ID_WIDTH-1:0]  r_id;
  logic [7:0]                r_level_out;
  logic                      r_shv_out;
  logic                      w_win_vld;
  logic [CLIC_ID_WIDTH-1:0]  w_win_id;
  logic [7:0]                w_win_level;
  logic                      w_win_shv;

  always_comb begin
    w_wr_cfg.ie    = cfg_ie_i;
    w_wr_cfg.level = cfg_level_i;
    w_wr_cfg.shv   = cfg_shv_i;
`ifdef CV32E40X_CLIC_EDGE_TRIG_EN
    w_wr_cfg.trig  = clic_trig_e'(cfg_trig_i);
`else
    w_wr_cfg.trig  = CLIC_TRIG_LEVEL;
`endif
    w_wr_sel = '0;
    w_lvl_nz = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_wr_sel[i] = cfg_we_i && (cfg_id_i == CLIC_ID_WIDTH'(i));
      w_lvl_nz[i] = |r_level[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_q <= '0;
      r_ie    <= '0;
      r_shv   <= '0;
      r_level <= '0;
    end else begin
      r_irq_q <= irq_src_i;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_wr_sel[i]) begin
          r_ie[i]    <= w_wr_cfg.ie;
          r_level[i] <= w_wr_cfg.level;
          r_shv[i]   <= w_wr_cfg.shv;
        end
      end
    end
  end

  assign w_ack_vld = irq_ack_i && (r_state == PRESENT) && (irq_ack_id_i == r_id);

`ifdef CV32E40X_CLIC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] r_trig;
  logic [NUM_SRC-1:0] r_edge_pend;
  logic [NUM_SRC-1:0] w_edge_pulse;

  assign w_edge_pulse = irq_src_i & ~r_irq_q;

  // Trigger-mode change wins over everything, then a new edge beats an ack clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig      <= '0;
      r_edge_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_wr_sel[i]) begin
          r_trig[i] <= (w_wr_cfg.trig == CLIC_TRIG_EDGE);
        end
        if (w_wr_sel[i] && ((w_wr_cfg.trig == CLIC_TRIG_EDGE) != r_trig[i])) begin
          r_edge_pend[i] <= 1'b0;
        end else if (w_edge_pulse[i]) begin
          r_edge_pend[i] <= 1'b1;
        end else if (w_ack_vld && (irq_ack_id_i == CLIC_ID_WIDTH'(i))) begin
          r_edge_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign w_pending = (r_trig & r_edge_pend) | (~r_trig & r_irq_q);
`else
  logic w_unused_trig;
  assign w_unused_trig = cfg_trig_i ^ w_wr_cfg.trig;
  assign w_pending     = r_irq_q;
`endif

  assign w_eligible = w_pending & r_ie & w_lvl_nz;

  cv32e40x_clic_arb_tree #(
    .NUM_SRC       (NUM_SRC),
    .CLIC_ID_WIDTH (CLIC_ID_WIDTH)
  ) u_arb_tree (
    .i_eligible (w_eligible),
    .i_level    (r_level),
    .i_shv      (r_shv),
    .o_valid    (w_win_vld),
    .o_id       (w_win_id),
    .o_level    (w_win_level),
    .o_shv      (w_win_shv)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = PRESENT;
          w_load      = 1'b1;
        end
      end
      PRESENT: begin
        if (w_ack_vld) begin
          w_state_nxt = HOLD;
        end else if (w_win_vld) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_level_out <= '0;
      r_shv_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_id        <= w_win_id;
        r_level_out <= w_win_level;
        r_shv_out   <= w_win_shv;
      end
    end
  end

  assign clic_irq_o       = (r_state == PRESENT);
  assign clic_irq_id_o    = r_id;
  assign clic_irq_level_o = r_level_out;
  assign clic_irq_shv_o   = r_shv_out;
  assign clic_irq_priv_o  = PRIV_LVL_M;
  assign pending_o        = w_pending;

endmodule
